// File: rtl/dff_reg.sv
// dff_reg: a Width-bit register bank, organised as a Depth-stage delay line
// with a capture enable and a fill-status flag. With the defaults (Depth=1,
// en_i tied high) it is a plain Width-bit D flip-flop with one cycle of latency.
//
// Ports:
//   clk_i    - clock; all state changes on the rising edge only
//   rst_i    - synchronous active-high reset; takes priority over en_i
//   en_i     - capture enable; when low, every stage and the fill count hold
//   i        - data in, sampled at the rising edge
//   o        - data out, taken from the last stage (never combinational from i)
//   valid_o  - high once Depth enabled captures have occurred since reset
module dff_reg #(
  parameter int unsigned      Width      = 4,
  parameter int unsigned      Depth      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] i,
  output logic [Width-1:0] o,
  output logic             valid_o
);

  // The fill counter saturates at Depth, so it needs enough bits to hold Depth itself.
  localparam int unsigned     CntW   = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(Depth);

  logic [Depth-1:0][Width-1:0] stage_q, stage_d;
  logic [CntW-1:0]             cnt_q, cnt_d;

  // Next-state: shift one place toward the output on an enabled edge, else hold.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (en_i) begin
      stage_d[0] = i;
      for (int k = 1; k < int'(Depth); k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Reset is checked first so it wins over en_i and discards any in-flight data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= {Depth{ResetValue}};
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o       = stage_q[Depth-1];
  assign valid_o = (cnt_q == CntMax);

endmodule

// File: tb/tb_dff_reg.sv
module tb_dff_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] din;

  logic [3:0] o_d1, o_d3, o_ra;
  logic       v_d1, v_d3, v_ra;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard: expected output / valid pushed at drive time, popped after the edge.
  logic [3:0] exp_q[$];
  logic       exp_v_q[$];

  dff_reg #(.Width(4), .Depth(1), .ResetValue(4'h0)) u_d1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .i(din), .o(o_d1), .valid_o(v_d1)
  );

  dff_reg #(.Width(4), .Depth(3), .ResetValue(4'h0)) u_d3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .i(din), .o(o_d3), .valid_o(v_d3)
  );

  dff_reg #(.Width(4), .Depth(1), .ResetValue(4'hA)) u_ra (
    .clk_i(clk), .rst_i(rst), .en_i(en), .i(din), .o(o_ra), .valid_o(v_ra)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; din = 4'h5;
    tick();
    total_cnt++;
    if (o_d1 !== 4'h0) $display("FAIL reset_o_d1 got=%h want=%h", o_d1, 4'h0);
    else pass_cnt++;
    total_cnt++;
    if (v_d1 !== 1'b0) $display("FAIL reset_valid_d1 got=%b want=%b", v_d1, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (o_d3 !== 4'h0) $display("FAIL reset_o_d3 got=%h want=%h", o_d3, 4'h0);
    else pass_cnt++;
    total_cnt++;
    if (v_d3 !== 1'b0) $display("FAIL reset_valid_d3 got=%b want=%b", v_d3, 1'b0);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [3:0] seq [6];
    logic [3:0] want;
    seq = '{4'h7, 4'h9, 4'h2, 4'h6, 4'h3, 4'h4};
    rst = 1'b0; en = 1'b1;
    foreach (seq[n]) begin
      din = seq[n];
      exp_q.push_back(seq[n]);
      tick();
      want = exp_q.pop_front();
      total_cnt++;
      if (o_d1 !== want) $display("FAIL basic_o[%0d] got=%h want=%h", n, o_d1, want);
      else pass_cnt++;
      total_cnt++;
      if (v_d1 !== 1'b1) $display("FAIL basic_valid[%0d] got=%b want=%b", n, v_d1, 1'b1);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    logic [3:0] want;
    // We sit just after an edge here; 9 is gone again before the next edge.
    din = 4'h9;
    #3;
    din = 4'h2;
    exp_q.push_back(4'h2);
    tick();
    want = exp_q.pop_front();
    total_cnt++;
    if (o_d1 !== want) $display("FAIL glitch_o got=%h want=%h", o_d1, want);
    else pass_cnt++;
  endtask

  task automatic test_enable_hold();
    logic [3:0] want;
    din = 4'h6; en = 1'b1;
    exp_q.push_back(4'h6);
    tick();
    want = exp_q.pop_front();
    total_cnt++;
    if (o_d1 !== want) $display("FAIL hold_load got=%h want=%h", o_d1, want);
    else pass_cnt++;
    en = 1'b0; din = 4'h3;
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(4'h6);
      tick();
      want = exp_q.pop_front();
      total_cnt++;
      if (o_d1 !== want) $display("FAIL hold_o[%0d] got=%h want=%h", n, o_d1, want);
      else pass_cnt++;
      total_cnt++;
      if (v_d1 !== 1'b1) $display("FAIL hold_valid[%0d] got=%b want=%b", n, v_d1, 1'b1);
      else pass_cnt++;
    end
    en = 1'b1;
    exp_q.push_back(4'h3);
    tick();
    want = exp_q.pop_front();
    total_cnt++;
    if (o_d1 !== want) $display("FAIL hold_release got=%h want=%h", o_d1, want);
    else pass_cnt++;
  endtask

  // Drive one edge on the Depth=3 instance and compare against the pushed expectation.
  task automatic d3_step(input logic r, input logic e, input logic [3:0] d,
                         input logic [3:0] want_o, input logic want_v, input int tag);
    logic [3:0] eo;
    logic       ev;
    rst = r; en = e; din = d;
    exp_q.push_back(want_o);
    exp_v_q.push_back(want_v);
    tick();
    eo = exp_q.pop_front();
    ev = exp_v_q.pop_front();
    total_cnt++;
    if (o_d3 !== eo) $display("FAIL depth3_o[%0d] got=%h want=%h", tag, o_d3, eo);
    else pass_cnt++;
    total_cnt++;
    if (v_d3 !== ev) $display("FAIL depth3_valid[%0d] got=%b want=%b", tag, v_d3, ev);
    else pass_cnt++;
  endtask

  task automatic test_depth3();
    d3_step(1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 0);
    // Fill: o lags by three edges, valid rises on the third enabled edge.
    d3_step(1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1);
    d3_step(1'b0, 1'b1, 4'h2, 4'h0, 1'b0, 2);
    d3_step(1'b0, 1'b1, 4'h3, 4'h1, 1'b1, 3);
    d3_step(1'b0, 1'b1, 4'h4, 4'h2, 1'b1, 4);
    d3_step(1'b0, 1'b1, 4'h0, 4'h3, 1'b1, 5);
    // Hold, then resume: pipeline contents are 0,4,3 (input side first).
    d3_step(1'b0, 1'b0, 4'h9, 4'h3, 1'b1, 6);
    d3_step(1'b0, 1'b1, 4'h5, 4'h4, 1'b1, 7);
    // Reset mid-stream discards everything and clears the fill count.
    d3_step(1'b1, 1'b1, 4'h7, 4'h0, 1'b0, 8);
    d3_step(1'b0, 1'b1, 4'h8, 4'h0, 1'b0, 9);
    d3_step(1'b0, 1'b1, 4'h9, 4'h0, 1'b0, 10);
    d3_step(1'b0, 1'b1, 4'hA, 4'h8, 1'b1, 11);
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; en = 1'b1; din = 4'hF;
    tick();
    total_cnt++;
    if (o_ra !== 4'hA) $display("FAIL prio_o_ra got=%h want=%h", o_ra, 4'hA);
    else pass_cnt++;
    total_cnt++;
    if (v_ra !== 1'b0) $display("FAIL prio_valid_ra got=%b want=%b", v_ra, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (o_d1 !== 4'h0) $display("FAIL prio_o_d1 got=%h want=%h", o_d1, 4'h0);
    else pass_cnt++;
    rst = 1'b0; din = 4'h5;
    tick();
    total_cnt++;
    if (o_ra !== 4'h5) $display("FAIL prio_capture got=%h want=%h", o_ra, 4'h5);
    else pass_cnt++;
    total_cnt++;
    if (v_ra !== 1'b1) $display("FAIL prio_capture_valid got=%b want=%b", v_ra, 1'b1);
    else pass_cnt++;
    // Reset also overrides a hold.
    rst = 1'b1; en = 1'b0; din = 4'h1;
    tick();
    total_cnt++;
    if (o_ra !== 4'hA) $display("FAIL prio_reset_hold got=%h want=%h", o_ra, 4'hA);
    else pass_cnt++;
    total_cnt++;
    if (v_ra !== 1'b0) $display("FAIL prio_reset_hold_valid got=%b want=%b", v_ra, 1'b0);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din = 4'h0;
    test_reset();
    test_basic();
    test_glitch();
    test_enable_hold();
    test_depth3();
    test_reset_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
